// File: rtl/imem_port_arbiter.sv
// Shares one byte-addressed big-endian instruction-memory port between fetch and a word loader.
// Latency: fetch is served combinationally in the request cycle; an accepted word is written over the next 4 cycles.
// Backpressure: fetch stalls on !if_grant, the loader holds its word until ld_ready; fetch wins unless the loader is starved.
module imem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_pc,
  output logic              if_grant,
  output logic [31:0]       if_instr,
  output logic              if_misalign,
  input  logic              ld_valid,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_busy,
  output logic [15:0]       load_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  // Starve counter only needs to reach STARVE_MAX, where it saturates.
  localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    W1,
    W2,
    W3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-3:0] r_word;        // word index of the load base; byte offset comes from r_byte_sel
  logic [31:0]       r_data;
  logic [SW-1:0]     r_starve;
  logic [15:0]       r_load_count;
  logic              r_mem_we;
  logic [1:0]        r_byte_sel;
  logic [7:0]        r_wbyte;
  logic              r_done;

  logic w_idle;
  logic w_misalign;
  logic w_starved;
  logic w_accept;
  logic w_fetch;
  logic w_unused_bits;

  // Address bits outside the memory window and the loader's byte offset carry no information here.
  assign w_unused_bits = ^{if_pc[31:ADDR_W], ld_addr[31:ADDR_W], ld_addr[1:0]};

  // Arbitration is decided in the same cycle so a fetch can be served with zero latency.
  always_comb begin
    w_idle     = (r_state == IDLE) && !reset;
    w_misalign = if_req && (if_pc[1:0] != 2'b00);
    w_starved  = (r_starve == STARVE_LIM);
    w_accept   = w_idle && ld_valid && (!if_req || w_misalign || w_starved);
    w_fetch    = w_idle && !w_accept && if_req && !w_misalign;
  end

  // Memory port and handshake outputs; write-phase values come straight from registers.
  always_comb begin
    if_grant    = w_fetch;
    if_instr    = w_fetch ? mem_rdata : 32'h0;
    if_misalign = !reset && w_misalign;
    ld_ready    = w_accept;
    ld_done     = r_done && !reset;
    ld_busy     = (r_state != IDLE);
    load_count  = r_load_count;
    mem_we      = r_mem_we;
    mem_wdata   = r_wbyte;
    mem_addr    = '0;
    if (r_mem_we) begin
      mem_addr = {r_word, r_byte_sel};
    end else if (w_fetch) begin
      mem_addr = if_pc[ADDR_W-1:0];
    end
  end

  // Write sequencer: captures an accepted word and emits its bytes MSB first, one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_data       <= '0;
      r_starve     <= '0;
      r_load_count <= '0;
      r_mem_we     <= 1'b0;
      r_byte_sel   <= 2'd0;
      r_wbyte      <= 8'h00;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= W0;
            r_word     <= ld_addr[ADDR_W-1:2];
            r_data     <= ld_data;
            r_starve   <= '0;
            r_mem_we   <= 1'b1;
            r_byte_sel <= 2'd0;
            r_wbyte    <= ld_data[31:24];
            r_done     <= 1'b0;
          end else if (w_fetch) begin
            // Only consecutive fetch wins against a waiting loader count toward starvation.
            if (ld_valid) begin
              if (r_starve != STARVE_LIM) begin
                r_starve <= r_starve + SW'(1);
              end
            end else begin
              r_starve <= '0;
            end
          end
        end
        W0: begin
          r_state    <= W1;
          r_byte_sel <= 2'd1;
          r_wbyte    <= r_data[23:16];
        end
        W1: begin
          r_state    <= W2;
          r_byte_sel <= 2'd2;
          r_wbyte    <= r_data[15:8];
        end
        W2: begin
          r_state    <= W3;
          r_byte_sel <= 2'd3;
          r_wbyte    <= r_data[7:0];
          r_done     <= 1'b1;
        end
        W3: begin
          r_state      <= IDLE;
          r_load_count <= r_load_count + 16'd1;
          r_mem_we     <= 1'b0;
          r_byte_sel   <= 2'd0;
          r_wbyte      <= 8'h00;
          r_done       <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_mem_we   <= 1'b0;
          r_byte_sel <= 2'd0;
          r_wbyte    <= 8'h00;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
// Includes a 16 KB byte memory behaving like the real array (combinational read, write on the clock edge).
module tb_imem_port_arbiter;

  localparam int AW = 14;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_pc;
  logic          if_grant;
  logic [31:0]   if_instr;
  logic          if_misalign;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_busy;
  logic [15:0]   load_count;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;

  logic [7:0]    mem     [0:16383];
  logic [7:0]    ref_mem [0:16383];
  logic [AW-1:0] ra1, ra2, ra3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_grant   (if_grant),
    .if_instr   (if_instr),
    .if_misalign(if_misalign),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_busy    (ld_busy),
    .load_count (load_count),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata)
  );

  assign ra1 = mem_addr + 14'd1;
  assign ra2 = mem_addr + 14'd2;
  assign ra3 = mem_addr + 14'd3;
  assign mem_rdata = {mem[mem_addr], mem[ra1], mem[ra2], mem[ra3]};

  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
  end

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; if_pc = 32'd0; ld_valid = 1'b1; ld_addr = 32'd0; ld_data = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({if_grant, ld_ready, mem_we, ld_done, ld_busy, if_misalign} !== 6'b0) begin
        n_bad++; $display("FAIL reset_flags cyc%0d: got %b expected 000000", c,
                          {if_grant, ld_ready, mem_we, ld_done, ld_busy, if_misalign});
      end
      n_cmp++;
      if ({load_count, if_instr, mem_addr, mem_wdata} !== {16'd0, 32'd0, 14'd0, 8'd0}) begin
        n_bad++; $display("FAIL reset_values cyc%0d: got cnt=%h instr=%h addr=%h wd=%h expected all zero",
                          c, load_count, if_instr, mem_addr, mem_wdata);
      end
    end
    reset = 1'b0; if_req = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    mem[100] <= 8'h48; mem[101] <= 8'h08; mem[102] <= 8'h00; mem[103] <= 8'h00;
    if_req = 1'b1; if_pc = 32'd100;
    #1;
    n_cmp++;
    if ({if_grant, mem_addr, if_instr} !== {1'b1, 14'd100, 32'h4808_0000}) begin
      n_bad++; $display("FAIL fetch: got g=%b a=%0d i=%h expected g=1 a=100 i=48080000", if_grant, mem_addr, if_instr);
    end
    @(negedge clk);
    if_pc = 32'h0003_0064;
    #1;
    n_cmp++;
    if ({if_grant, mem_addr, if_instr} !== {1'b1, 14'd100, 32'h4808_0000}) begin
      n_bad++; $display("FAIL fetch_trunc: got g=%b a=%0d i=%h expected g=1 a=100 i=48080000", if_grant, mem_addr, if_instr);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_cmp++;
    if ({if_grant, if_instr, mem_addr} !== {1'b0, 32'd0, 14'd0}) begin
      n_bad++; $display("FAIL fetch_idle: got g=%b i=%h a=%0d expected g=0 i=0 a=0", if_grant, if_instr, mem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [7:0] eb [4];
    eb[0] = 8'h24; eb[1] = 8'h13; eb[2] = 8'h00; eb[3] = 8'h05;
    if_req = 1'b0; ld_valid = 1'b1; ld_addr = 32'd203; ld_data = 32'h2413_0005;
    #1;
    n_cmp++;
    if ({ld_ready, if_grant, mem_we} !== 3'b100) begin
      n_bad++; $display("FAIL load_accept: got rdy/g/we=%b expected 100", {ld_ready, if_grant, mem_we});
    end
    @(negedge clk);
    ld_valid = 1'b0; if_req = 1'b1; if_pc = 32'd100;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({mem_we, ld_busy, ld_done, ld_ready, if_grant, mem_addr, mem_wdata} !==
          {1'b1, 1'b1, (k == 3), 1'b0, 1'b0, 14'(200 + k), eb[k]}) begin
        n_bad++; $display("FAIL load_byte%0d: got we=%b busy=%b done=%b rdy=%b g=%b a=%0d d=%h expected 1 1 %0d 0 0 a=%0d d=%h",
                          k, mem_we, ld_busy, ld_done, ld_ready, if_grant, mem_addr, mem_wdata, (k == 3), 200 + k, eb[k]);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({mem_we, ld_busy, ld_done, load_count} !== {3'b000, 16'd1}) begin
      n_bad++; $display("FAIL load_end: got we=%b busy=%b done=%b cnt=%0d expected 0 0 0 1", mem_we, ld_busy, ld_done, load_count);
    end
    n_cmp++;
    if ({mem[200], mem[201], mem[202], mem[203]} !== 32'h2413_0005) begin
      n_bad++; $display("FAIL load_mem: got %h expected 24130005", {mem[200], mem[201], mem[202], mem[203]});
    end
    n_cmp++;
    if ({if_grant, if_instr} !== {1'b1, 32'h4808_0000}) begin
      n_bad++; $display("FAIL load_fetch_resume: got g=%b i=%h expected g=1 i=48080000", if_grant, if_instr);
    end
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic eg, er;
    if_req = 1'b1; if_pc = 32'd0; ld_valid = 1'b1; ld_addr = 32'h0000_1000; ld_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      #1;
      eg = (c < 4) || (c >= 9);
      er = (c == 4);
      n_cmp++;
      if ({if_grant, ld_ready} !== {eg, er}) begin
        n_bad++; $display("FAIL starve_cyc%0d: got g=%b rdy=%b expected g=%b rdy=%b", c, if_grant, ld_ready, eg, er);
      end
      if (c == 9) begin
        n_cmp++;
        if (load_count !== 16'd2) begin
          n_bad++; $display("FAIL starve_count: got %0d expected 2", load_count);
        end
      end
      @(negedge clk);
      if (c == 4) ld_valid = 1'b0;
    end
    if_req = 1'b0;
  endtask

  task automatic test_misalign();
    if_req = 1'b1; if_pc = 32'd102; ld_valid = 1'b0;
    #1;
    n_cmp++;
    if ({if_misalign, if_grant, mem_we, ld_ready, if_instr} !== {4'b1000, 32'd0}) begin
      n_bad++; $display("FAIL misalign: got m=%b g=%b we=%b rdy=%b i=%h expected 1 0 0 0 0",
                        if_misalign, if_grant, mem_we, ld_ready, if_instr);
    end
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'd300; ld_data = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if ({if_misalign, if_grant, ld_ready} !== 3'b101) begin
      n_bad++; $display("FAIL misalign_load: got m/g/rdy=%b expected 101", {if_misalign, if_grant, ld_ready});
    end
    @(negedge clk);
    ld_valid = 1'b0; if_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if ({load_count, mem[300], mem[301], mem[302], mem[303]} !== {16'd3, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL misalign_load_done: got cnt=%0d mem=%h expected 3 cafef00d",
                        load_count, {mem[300], mem[301], mem[302], mem[303]});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem[400] <= 8'hEE; mem[401] <= 8'hEE; mem[402] <= 8'hEE; mem[403] <= 8'hEE;
    if_req = 1'b0; ld_valid = 1'b1; ld_addr = 32'd400; ld_data = 32'hA1B2_C3D4;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++; $display("FAIL rmid_accept: got rdy=%b expected 1", ld_ready);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_we, ld_done, mem_addr, mem_wdata} !== {2'b10, 14'd401, 8'hB2}) begin
      n_bad++; $display("FAIL rmid_t2: got we=%b done=%b a=%0d d=%h expected 1 0 401 b2", mem_we, ld_done, mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, ld_busy, ld_done, load_count} !== {3'b000, 16'd0}) begin
      n_bad++; $display("FAIL rmid_t3: got we=%b busy=%b done=%b cnt=%0d expected 0 0 0 0", mem_we, ld_busy, ld_done, load_count);
    end
    n_cmp++;
    if ({mem[400], mem[401], mem[402], mem[403]} !== 32'hA1B2_EEEE) begin
      n_bad++; $display("FAIL rmid_mem: got %h expected a1b2eeee", {mem[400], mem[401], mem[402], mem[403]});
    end
    if_req = 1'b1; if_pc = 32'd200;
    #1;
    n_cmp++;
    if ({if_grant, if_instr} !== {1'b1, 32'h2413_0005}) begin
      n_bad++; $display("FAIL rmid_fetch: got g=%b i=%h expected g=1 i=24130005", if_grant, if_instr);
    end
    @(negedge clk);
    if_req = 1'b0;
  endtask

  // Reference model: phase -1 means idle, 0..3 is the byte being written this cycle.
  task automatic test_random();
    int            phase = -1;
    int            starve = 0;
    int            lcnt = 0;
    int            diffs = 0;
    logic [13:0]   base = '0;
    logic [31:0]   wd = '0;
    logic          pend = 1'b0;
    logic [31:0]   pa = '0, pd = '0;
    logic          e_acc, e_gr, e_mis, e_wr;
    logic [13:0]   e_addr, a;
    logic [7:0]    e_wd;
    logic [31:0]   e_instr;
    for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
    for (int cyc = 0; cyc < 800 || phase >= 0 || pend; cyc++) begin
      if (cyc < 800 && !pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        pa = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
        pd = $urandom;
      end
      ld_valid = pend; ld_addr = pa; ld_data = pd;
      if_req = (cyc < 800) && ($urandom_range(0, 3) != 0);
      if_pc = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) if_pc[1:0] = 2'($urandom_range(1, 3));
      #1;
      e_wr  = (phase >= 0);
      e_mis = if_req && (if_pc[1:0] != 2'b00);
      if (e_wr) begin
        e_acc = 1'b0; e_gr = 1'b0;
      end else begin
        e_acc = ld_valid && (!if_req || e_mis || starve == SM);
        e_gr  = !e_acc && if_req && !e_mis;
      end
      a       = if_pc[13:0];
      e_addr  = e_wr ? base + 14'(phase) : (e_gr ? a : 14'd0);
      e_wd    = e_wr ? 8'(wd >> (24 - 8 * phase)) : 8'd0;
      e_instr = e_gr ? {ref_mem[a], ref_mem[a + 14'd1], ref_mem[a + 14'd2], ref_mem[a + 14'd3]} : 32'd0;
      n_cmp++;
      if ({if_grant, ld_ready, if_misalign, mem_we, ld_busy, ld_done} !== {e_gr, e_acc, e_mis, e_wr, e_wr, phase == 3}) begin
        n_bad++; $display("FAIL rand_flags cyc%0d: got %b expected %b", cyc,
                          {if_grant, ld_ready, if_misalign, mem_we, ld_busy, ld_done}, {e_gr, e_acc, e_mis, e_wr, e_wr, phase == 3});
      end
      n_cmp++;
      if ({mem_addr, mem_wdata} !== {e_addr, e_wd}) begin
        n_bad++; $display("FAIL rand_port cyc%0d: got a=%h d=%h expected a=%h d=%h", cyc, mem_addr, mem_wdata, e_addr, e_wd);
      end
      n_cmp++;
      if (if_instr !== e_instr) begin
        n_bad++; $display("FAIL rand_instr cyc%0d: got %h expected %h", cyc, if_instr, e_instr);
      end
      n_cmp++;
      if (load_count !== 16'(lcnt)) begin
        n_bad++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", cyc, load_count, lcnt);
      end
      if (e_wr) begin
        ref_mem[base + 14'(phase)] = e_wd;
        if (phase == 3) begin phase = -1; lcnt++; end
        else phase++;
      end else if (e_acc) begin
        base = {pa[13:2], 2'b00}; wd = pd; phase = 0; starve = 0; pend = 1'b0;
      end else if (e_gr) begin
        starve = ld_valid ? ((starve < SM) ? starve + 1 : SM) : 0;
      end
      @(negedge clk);
    end
    ld_valid = 1'b0; if_req = 1'b0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_bad++; $display("FAIL rand_mem: got %0d differing bytes expected 0", diffs);
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_pc = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 16384; i++) mem[i] <= 8'($urandom);
    test_reset();
    test_fetch();
    test_load();
    test_starvation();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
